l2_port_arbiter: RTL
====================

# l2_port_arbiter

Shares the single-port L2 SRAM of the JTAG-to-L2 test system between N TCDM-style masters: master 0 is the JTAG debug bridge, the others are SoC-side requesters. Per cycle it grants at most one request by round-robin, with an optional fixed-priority override. It decodes the address window and forwards the access to the SRAM. One cycle later it routes the read data or write acknowledge back to the granted master. Out-of-window accesses never reach the SRAM and return an error response.

## Interface
Parameters:
- N_MST, 2, number of masters (≥2); IDX_W = max(1, $clog2(N_MST))
- BASE_ADDR, 32'h0000_0000, byte base address of the L2 window
- MEM_WORDS, 16384, SRAM depth in 32-bit words; MEM_AW = $clog2(MEM_WORDS)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- m_req_i  in  N_MST  request per master
- m_addr_i  in  N_MST×32  byte address
- m_we_i  in  N_MST  1 = write
- m_be_i  in  N_MST×4  byte enables
- m_wdata_i  in  N_MST×32  write data
- m_gnt_o  out  N_MST  grant, combinational
- m_rvalid_o  out  N_MST  response valid, registered
- m_rdata_o  out  N_MST×32  read data, registered
- m_err_o  out  N_MST  error flag, qualified by rvalid
- prio_en_i  in  1  enable priority override
- prio_mst_i  in  IDX_W  master favoured when prio_en_i = 1
- mem_req_o  out  1  SRAM chip select
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  MEM_AW  SRAM word address
- mem_be_o  out  4  SRAM byte enables
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o

## Operation
- Round-robin pointer rr_q (IDX_W bits). Search starts at rr_q, ascending with wrap; the first requesting master wins.
- After a round-robin grant to master k: rr_q ← (k+1) mod N_MST.
- Override: if prio_en_i = 1 and m_req_i[prio_mst_i] = 1, that master is granted and rr_q is unchanged.
- An out-of-range prio_mst_i (≥ N_MST) disables the override.
- Window hit: addr ≥ BASE_ADDR and (addr − BASE_ADDR) < MEM_WORDS×4, computed in 33-bit arithmetic so wrap-around never aliases a hit.
- mem_addr_o = (addr − BASE_ADDR)[MEM_AW+1:2]. Address bits [1:0] are ignored; mem_be_o carries the byte lanes.
- Grant on hit: mem_req_o = 1, and mem_we_o/mem_be_o/mem_wdata_o are taken from the winner.
- Grant on miss: the master is still granted, mem_req_o = 0, and an error response is scheduled.
- Response pipeline register: valid, master index, is_read, err.
- Next cycle, for the recorded master only:
  - rvalid = 1
  - rdata = mem_rdata_i for a read hit, 0 for a write or a miss
  - err = miss
- All other masters: rvalid = 0 and rdata = 0.
- No request: all grants 0, mem_req_o = 0, mem_we_o/mem_be_o/mem_wdata_o/mem_addr_o = 0.
- A master holds m_req_i and its request fields stable until granted. Dropping the request before grant is permitted; the request is then discarded.

## Timing
- Grant latency is 0 cycles (combinational from req/prio/rr_q). Response latency is exactly 1 cycle after grant.
- Throughput is one access per cycle. Back-to-back grants to the same or different masters pipeline without bubbles.
- The response of grant n and grant n+1 may appear in consecutive cycles to different masters.
- Reset (asynchronous): rr_q = 0, response register cleared, all m_rvalid_o/m_rdata_o/m_err_o = 0. Grants and SRAM outputs are 0 while rst_i = 1.
- Reset asserted with a response in flight: that response is dropped and never delivered. The SRAM write in the same cycle may still complete.
- Simultaneous requests from all masters: exactly one grant. The others wait without losing state.

## Structure
- Package l2_arb_pkg holds:
  - typedef l2_req_t {addr, we, be, wdata}
  - typedef l2_rsp_t {rvalid, rdata, err}
  - localparam WORD_BYTES = 4
- Sub-module l2_rr_arbiter (parameter N_MST):
  - inputs: req vector, rr_q, prio_en, prio_idx
  - outputs: one-hot grant, winner index, rr_d
- The top module holds the address decode, SRAM muxing, and response register.

## Test plan
- Write then read, no contention: master 0 writes 32'hABBAABBA to 0x0, then reads 0x0. gnt is returned in the same cycle; on the read, rvalid rises 1 cycle later with rdata = 32'hABBAABBA and err = 0.
- Contention: masters 0 and 1 request continuously, 8 reads, after reset. Grants alternate 0,1,0,1… and each master receives 4 rvalid pulses, in order.
- Override: prio_en_i = 1, prio_mst_i = 1, both masters requesting for 4 cycles. Master 1 is granted every cycle and rr_q stays 0. When the override is released, master 0 is granted first.
- Out of window: a read at BASE_ADDR + MEM_WORDS×4 and a read at 32'hFFFF_FFFC. gnt = 1, mem_req_o = 0, and the next cycle gives rvalid = 1, err = 1, rdata = 0.
- Byte enables: write 32'h11223344 with be = 4'b0011 over 32'hFFFFFFFF, then read. Data = 32'hFFFF3344.
- Reset mid-flight: assert rst_i in the cycle after a read grant. No rvalid is seen, and after release the first grant goes to master 0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
package l2_arb_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic                  we;
        logic [WORD_BYTES-1:0] be;
        logic [DATA_W-1:0]     wdata;
    } l2_req_t;

    typedef struct packed {
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } l2_rsp_t;

endpackage

// File: rtl/l2_rr_arbiter.sv
// Round-robin request arbiter with a single-master priority override.
module l2_rr_arbiter #(
    parameter int unsigned N_MST = 2,
    localparam int unsigned IDX_W = ($clog2(N_MST) > 1) ? $clog2(N_MST) : 1
) (
    input  logic [N_MST-1:0] req,
    input  logic [IDX_W-1:0] rr_q,
    input  logic             prio_en,
    input  logic [IDX_W-1:0] prio_idx,
    output logic [N_MST-1:0] gnt,
    output logic [IDX_W-1:0] win_idx,
    output logic [IDX_W-1:0] rr_d
);

    logic        prio_hit;
    logic        found;
    int unsigned cand;

    // Override only applies to an in-range index that is actually requesting
    always_comb begin
        prio_hit = 1'b0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            if (prio_en && (prio_idx == IDX_W'(i)) && req[IDX_W'(i)]) begin
                prio_hit = 1'b1;
            end
        end
    end

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        rr_d    = rr_q;
        found   = 1'b0;
        cand    = 0;
        if (prio_hit) begin
            gnt[prio_idx] = 1'b1;
            win_idx       = prio_idx;
        end else begin
            for (int unsigned i = 0; i < N_MST; i++) begin
                cand = 32'(rr_q) + i;
                if (cand >= N_MST) begin
                    cand = cand - N_MST;
                end
                if (!found && req[IDX_W'(cand)]) begin
                    found              = 1'b1;
                    gnt[IDX_W'(cand)]  = 1'b1;
                    win_idx            = IDX_W'(cand);
                    rr_d               = (cand == N_MST - 1) ? '0 : IDX_W'(cand + 1);
                end
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates N masters onto one single-port L2 SRAM with window decode and
// a one-cycle response path back to the granted master.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned N_MST     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 16384,
    localparam int unsigned IDX_W    = ($clog2(N_MST) > 1) ? $clog2(N_MST) : 1,
    localparam int unsigned MEM_AW   = $clog2(MEM_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_MST-1:0]            m_req_i,
    input  logic [N_MST-1:0][31:0]      m_addr_i,
    input  logic [N_MST-1:0]            m_we_i,
    input  logic [N_MST-1:0][3:0]       m_be_i,
    input  logic [N_MST-1:0][31:0]      m_wdata_i,
    output logic [N_MST-1:0]            m_gnt_o,
    output logic [N_MST-1:0]            m_rvalid_o,
    output logic [N_MST-1:0][31:0]      m_rdata_o,
    output logic [N_MST-1:0]            m_err_o,
    input  logic                        prio_en_i,
    input  logic [IDX_W-1:0]            prio_mst_i,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [MEM_AW-1:0]           mem_addr_o,
    output logic [3:0]                  mem_be_o,
    output logic [31:0]                 mem_wdata_o,
    input  logic [31:0]                 mem_rdata_i
);

    logic [N_MST-1:0] gnt;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;
    l2_req_t          sel;
    logic [32:0]      offset;
    logic             hit;
    logic             any_gnt;

    logic             rsp_valid_q;
    logic [IDX_W-1:0] rsp_idx_q;
    logic             rsp_read_q;
    logic             rsp_err_q;
    l2_rsp_t          rsp [N_MST];

    l2_rr_arbiter #(
        .N_MST (N_MST)
    ) u_arb (
        .req      (m_req_i),
        .rr_q     (rr_q),
        .prio_en  (prio_en_i),
        .prio_idx (prio_mst_i),
        .gnt      (gnt),
        .win_idx  (win_idx),
        .rr_d     (rr_d)
    );

    always_comb begin
        sel.addr  = m_addr_i[win_idx];
        sel.we    = m_we_i[win_idx];
        sel.be    = m_be_i[win_idx];
        sel.wdata = m_wdata_i[win_idx];
    end

    // 33-bit offset: a borrow (addr below base) shows up in bit 32 and can never alias a hit
    assign offset  = {1'b0, sel.addr} - {1'b0, BASE_ADDR};
    assign hit     = !offset[32] && (offset < (33'(MEM_WORDS) * 33'(WORD_BYTES)));
    assign any_gnt = (|gnt) && !rst_i;
    assign m_gnt_o = rst_i ? '0 : gnt;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (any_gnt && hit) begin
            mem_req_o   = 1'b1;
            mem_we_o    = sel.we;
            mem_addr_o  = offset[MEM_AW+1:2];
            mem_be_o    = sel.be;
            mem_wdata_o = sel.wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_read_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= any_gnt;
            rsp_idx_q   <= win_idx;
            rsp_read_q  <= !sel.we && hit;
            rsp_err_q   <= !hit;
        end
    end

    // Steer the single in-flight response to its master; everyone else sees zeros
    always_comb begin
        for (int unsigned i = 0; i < N_MST; i++) begin
            rsp[i].rvalid = rsp_valid_q && (rsp_idx_q == IDX_W'(i));
            rsp[i].err    = rsp[i].rvalid && rsp_err_q;
            rsp[i].rdata  = (rsp[i].rvalid && rsp_read_q) ? mem_rdata_i : '0;
            m_rvalid_o[i] = rsp[i].rvalid;
            m_err_o[i]    = rsp[i].err;
            m_rdata_o[i]  = rsp[i].rdata;
        end
    end

endmodule
